// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: opcode values and the FSM
// state encoding. Imported by fetch_op_decode and fetch_sequencer.
package fetch_pkg;

    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_BZ   = 4'hD;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_ISSUE  = 3'd2;
    localparam logic [2:0] ST_UPDATE = 3'd3;
    localparam logic [2:0] ST_HALTED = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_FETCH  = ST_FETCH,
        S_ISSUE  = ST_ISSUE,
        S_UPDATE = ST_UPDATE,
        S_HALTED = ST_HALTED
    } state_e;

endpackage

// File: rtl/fetch_op_decode.sv
// Combinational opcode decode for the fetch sequencer.
// Ports:
//   opcode    in  4  top nibble of the fetched instruction
//   zero_flag in  1  ALU zero flag, valid in the issue handshake cycle
//   is_halt   out 1  instruction stops the sequencer
//   do_load   out 1  PC takes the immediate (JMP, or BZ with zero_flag=1);
//                    when neither is_halt nor do_load, the PC increments
module fetch_op_decode
    import fetch_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       zero_flag,
    output logic       is_halt,
    output logic       do_load
);

    assign is_halt = (opcode == OP_HALT);
    assign do_load = (opcode == OP_JMP) || ((opcode == OP_BZ) && zero_flag);

endmodule

// File: rtl/fetch_sequencer.sv
// Control-side partner of the program counter. Fetches the word at PCout
// over a req/ready handshake, hands it to execute over valid/ready, then
// pulses PCinc or PCload (with PCdata) for one cycle before the next fetch.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start                      level; leaves IDLE/HALTED
//   PCout                      current PC from the program counter
//   PCdata/PCload/PCinc        PC control (registered, load/inc exclusive)
//   mem_req/mem_addr           instruction read request, address = PCout
//   mem_ready/mem_rdata        read response
//   instr/instr_valid          fetched word to execute
//   instr_ready                execute accepts instr
//   zero_flag                  sampled on the issue handshake
//   halted                     high in HALTED
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int N = 32,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] PCout,
    output logic [N-1:0] PCdata,
    output logic         PCload,
    output logic         PCinc,
    output logic         mem_req,
    output logic [N-1:0] mem_addr,
    input  logic         mem_ready,
    input  logic [W-1:0] mem_rdata,
    output logic [W-1:0] instr,
    output logic         instr_valid,
    input  logic         instr_ready,
    input  logic         zero_flag,
    output logic         halted
);

    localparam int IW = W - 4;
    localparam int XW = (N > IW) ? N : IW;

    state_e       state_q;
    logic [N-1:0] pcdata_q;
    logic         pcload_q, pcinc_q, mem_req_q, instr_valid_q, halted_q;
    logic [W-1:0] instr_q;

    logic         is_halt, do_load;
    logic [XW-1:0] imm_wide;
    logic [N-1:0] imm_ext;

    // Widen to whichever of N / IW is larger, then keep the low N bits:
    // zero-extends when N > IW, truncates when N < IW.
    assign imm_wide = XW'(instr_q[IW-1:0]);
    assign imm_ext  = imm_wide[N-1:0];

    fetch_op_decode u_dec (
        .opcode    (instr_q[W-1:W-4]),
        .zero_flag (zero_flag),
        .is_halt   (is_halt),
        .do_load   (do_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pcdata_q      <= '0;
            pcload_q      <= 1'b0;
            pcinc_q       <= 1'b0;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            instr_q       <= '0;
        end else begin
            // PC pulses are single-cycle: only set on the issue handshake.
            pcload_q <= 1'b0;
            pcinc_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_FETCH;
                        mem_req_q <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        instr_q       <= mem_rdata;
                        mem_req_q     <= 1'b0;
                        instr_valid_q <= 1'b1;
                        state_q       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (instr_ready) begin
                        instr_valid_q <= 1'b0;
                        if (is_halt) begin
                            halted_q <= 1'b1;
                            state_q  <= S_HALTED;
                        end else begin
                            state_q <= S_UPDATE;
                            if (do_load) begin
                                pcload_q <= 1'b1;
                                pcdata_q <= imm_ext;
                            end else begin
                                pcinc_q <= 1'b1;
                            end
                        end
                    end
                end
                S_UPDATE: begin
                    // The PC moves on this edge, so FETCH sees the new PCout.
                    state_q   <= S_FETCH;
                    mem_req_q <= 1'b1;
                end
                S_HALTED: begin
                    if (start) begin
                        halted_q  <= 1'b0;
                        mem_req_q <= 1'b1;
                        state_q   <= S_FETCH;
                    end
                end
                default: begin
                    state_q       <= S_IDLE;
                    mem_req_q     <= 1'b0;
                    instr_valid_q <= 1'b0;
                    halted_q      <= 1'b0;
                end
            endcase
        end
    end

    assign PCdata      = pcdata_q;
    assign PCload      = pcload_q;
    assign PCinc       = pcinc_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = PCout;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;

endmodule
